// File: rtl/phy_burst_tx_if.sv
// phy_burst_tx_if: valid/ready write stream feeding the burst transmitter FIFO
interface phy_burst_tx_if #(
    parameter int DQ_W = 8
);
    logic            s_valid;
    logic            s_ready;
    logic [DQ_W-1:0] s_data;
    modport master (output s_valid, s_data, input s_ready);
    modport slave (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/phy_burst_tx.sv
// phy_burst_tx: FIFO-fed fixed-length burst transmitter with preamble/postamble and differential strobe
// Optional data bus inversion per byte lane when PHY_TX_DBI_EN is defined.
module phy_burst_tx #(
    parameter int DQ_W       = 8,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PRE_CYC    = 1,
    parameter int POST_CYC   = 1
) (
    input  logic            clk,
    input  logic            rst,
    phy_burst_tx_if.slave   s,
    output logic [DQ_W-1:0] dq,
    output logic            dq_oe,
    output logic            dqs_p,
    output logic            dqs_n,
    output logic            dqs_oe,
    output logic            busy,
    output logic            burst_done
`ifdef PHY_TX_DBI_EN
    ,
    output logic [DQ_W/8-1:0] dbi
`endif
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (BURST_LEN > PRE_CYC) ? ((BURST_LEN > POST_CYC) ? BURST_LEN : POST_CYC)
                                                : ((PRE_CYC > POST_CYC) ? PRE_CYC : POST_CYC);
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2, POST = 2'd3;
    localparam logic [AW:0]   BL_C      = (AW+1)'(BURST_LEN);
    localparam logic [AW+1:0] BL_E      = (AW+2)'(BURST_LEN);
    localparam logic [AW:0]   FULL_C    = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] BL_LAST   = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_CYC - 1);

    logic [DQ_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     cnt;
    logic [AW+1:0]   cnt_eff;
    logic            push, pop;
    logic [1:0]      state, state_n;
    logic [CW-1:0]   cyc, cyc_n;
    logic [DQ_W-1:0] raw, dq_nx;
    logic            dqs_nx;

    assign s.s_ready = cnt != FULL_C;
    assign push      = s.s_valid && s.s_ready;
    assign pop       = state_n == DATA;
    assign cnt_eff   = {1'b0, cnt} + (AW+2)'(push);
    assign raw       = mem[rd_ptr];
    assign dqs_nx    = (state_n == DATA) && !cyc_n[0];

    // The seamless decision counts a push landing on the same edge as the last beat.
    always_comb begin
        state_n = state;
        cyc_n   = cyc + 1'b1;
        case (state)
            IDLE: begin
                cyc_n   = '0;
                state_n = (cnt >= BL_C) ? PRE : IDLE;
            end
            PRE: if (cyc == PRE_LAST) begin
                state_n = DATA;
                cyc_n   = '0;
            end
            DATA: if (cyc == BL_LAST) begin
                state_n = (cnt_eff >= BL_E) ? DATA : POST;
                cyc_n   = '0;
            end
            default: if (cyc == POST_LAST) begin
                state_n = IDLE;
                cyc_n   = '0;
            end
        endcase
    end

`ifdef PHY_TX_DBI_EN
    logic [DQ_W/8-1:0] dbi_nx;
    always_comb begin
        dq_nx  = raw;
        dbi_nx = '0;
        for (int i = 0; i < DQ_W/8; i++) begin
            if ($countones(raw[8*i +: 8]) < 4) begin
                dq_nx[8*i +: 8] = ~raw[8*i +: 8];
                dbi_nx[i]       = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) dbi <= rst ? '0 : (state_n == DATA) ? dbi_nx : '0;
`else
    assign dq_nx = raw;
`endif

    always_ff @(posedge clk) if (push) mem[wr_ptr] <= s.s_data;

    // Outputs are loaded from the next state so each registered value lines up with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            state      <= IDLE;
            cyc        <= '0;
            dq         <= '0;
            dq_oe      <= 1'b0;
            dqs_p      <= 1'b0;
            dqs_n      <= 1'b1;
            dqs_oe     <= 1'b0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            cnt        <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            state      <= state_n;
            cyc        <= cyc_n;
            dq         <= (state_n == DATA) ? dq_nx : '0;
            dq_oe      <= state_n == DATA;
            dqs_p      <= dqs_nx;
            dqs_n      <= ~dqs_nx;
            dqs_oe     <= state_n != IDLE;
            busy       <= state_n != IDLE;
            burst_done <= (state_n == DATA) && (cyc_n == BL_LAST);
        end
    end
endmodule

// File: tb/tb_phy_burst_tx.sv
// tb_phy_burst_tx: directed checks of phy_burst_tx with hand-computed cycle expectations
module tb_phy_burst_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phy_burst_tx_if #(.DQ_W(8)) sif ();
    phy_burst_tx_if #(.DQ_W(8)) bif ();

    logic [7:0] dq, b_dq;
    logic dq_oe, dqs_p, dqs_n, dqs_oe, busy, burst_done;
    logic b_dq_oe, b_dqs_p, b_dqs_n, b_dqs_oe, b_busy, b_burst_done;
`ifdef PHY_TX_DBI_EN
    logic [0:0] dbi, b_dbi;
`endif

    phy_burst_tx u_dut (
        .clk(clk), .rst(rst), .s(sif), .dq(dq), .dq_oe(dq_oe), .dqs_p(dqs_p), .dqs_n(dqs_n),
        .dqs_oe(dqs_oe), .busy(busy), .burst_done(burst_done)
`ifdef PHY_TX_DBI_EN
        , .dbi(dbi)
`endif
    );

    phy_burst_tx #(.PRE_CYC(12)) u_bp (
        .clk(clk), .rst(rst), .s(bif), .dq(b_dq), .dq_oe(b_dq_oe), .dqs_p(b_dqs_p), .dqs_n(b_dqs_n),
        .dqs_oe(b_dqs_oe), .busy(b_busy), .burst_done(b_burst_done)
`ifdef PHY_TX_DBI_EN
        , .dbi(b_dbi)
`endif
    );

`ifdef PHY_TX_DBI_EN
    phy_burst_tx_if #(.DQ_W(16)) dif ();
    logic [15:0] d_dq;
    logic [1:0] d_dbi;
    logic d_dq_oe, d_dqs_p, d_dqs_n, d_dqs_oe, d_busy, d_burst_done;
    phy_burst_tx #(.DQ_W(16)) u_dbi (
        .clk(clk), .rst(rst), .s(dif), .dq(d_dq), .dq_oe(d_dq_oe), .dqs_p(d_dqs_p), .dqs_n(d_dqs_n),
        .dqs_oe(d_dqs_oe), .busy(d_busy), .burst_done(d_burst_done), .dbi(d_dbi)
    );
`endif

    logic [13:0] obs;
    assign obs = {dq, dq_oe, dqs_oe, dqs_p, dqs_n, busy, burst_done};

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] got_q [$];

    always @(negedge clk) if (b_dq_oe) got_q.push_back(b_dq);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Push push_n beats from cycle 0; expect PRE at pre_at, data_n beats, one POST cycle.
    task automatic run(input logic [7:0] push_base, input int push_n, input logic [7:0] exp_base,
                       input int pre_at, input int data_n, input int cycles, input string name);
        logic d, act, p;
        int b;
        logic [13:0] e;
        for (int k = 0; k < cycles; k++) begin
            sif.s_valid = k < push_n;
            sif.s_data  = push_base + 8'(k);
            @(negedge clk);
            d   = (k > pre_at) && (k <= pre_at + data_n);
            act = (k >= pre_at) && (k <= pre_at + data_n + 1);
            b   = k - pre_at - 1;
            p   = d && (b % 2 == 0);
            e   = {d ? exp_base + 8'(b) : 8'h00, d, act, p, ~p, act, d && (b % 8 == 7)};
            chk($sformatf("%s k=%0d", name, k), 32'(obs), 32'(e));
            @(posedge clk);
            #1;
        end
        sif.s_valid = 1'b0;
    endtask

    initial begin
        int acc;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        bif.s_valid = 1'b0;
        bif.s_data  = '0;
`ifdef PHY_TX_DBI_EN
        dif.s_valid = 1'b0;
        dif.s_data  = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vec", 32'(obs), 32'h004);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(sif.s_ready), 32'd1);
        chk("bp_idle_after_rst", 32'({b_dq_oe, b_dqs_oe, b_dqs_n, b_busy}), 32'b0010);
        @(posedge clk);
        #1;

        run(8'h01, 8, 8'h01, 9, 8, 20, "single");
        run(8'h10, 16, 8'h10, 9, 16, 28, "seamless");
        run(8'h20, 7, 8'h00, 1000, 0, 25, "underfill");
        run(8'h27, 1, 8'h20, 2, 8, 13, "fill8");

        run(8'h30, 8, 8'h30, 9, 8, 13, "pre_rst");
        rst = 1'b1;
        @(negedge clk);
        chk("beat3", 32'(obs), 32'({8'h33, 6'b110110}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_burst", 32'(obs), 32'h004);
        chk("rst_mid_ready", 32'(sif.s_ready), 32'd1);
        @(posedge clk);
        #1;
        run(8'h40, 8, 8'h40, 9, 8, 20, "after_rst");

        acc = 0;
        for (int k = 0; k < 45; k++) begin
            bif.s_valid = k < 20;
            bif.s_data  = 8'(acc + 1);
            @(negedge clk);
            if (k == 16 || k == 17) chk($sformatf("bp_ready k=%0d", k), 32'(bif.s_ready), 32'd0);
            if (bif.s_valid && bif.s_ready) acc++;
            @(posedge clk);
            #1;
        end
        bif.s_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd16);
        chk("bp_out_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < got_q.size(); i++) chk($sformatf("bp_order i=%0d", i), 32'(got_q[i]), 32'(i + 1));

`ifdef PHY_TX_DBI_EN
        chk("dbi_idle", 32'(dbi), 32'd0);
        for (int k = 0; k < 20; k++) begin
            dif.s_valid = k < 8;
            dif.s_data  = k[0] ? 16'h0F0F : 16'h00FF;
            @(negedge clk);
            if (k == 9) chk("dbi_pre", 32'({d_dq, d_dbi}), 32'h0);
            if (k == 10) chk("dbi_00ff", 32'({d_dq, d_dbi}), 32'({16'hFFFF, 2'b10}));
            if (k == 11) chk("dbi_0f0f", 32'({d_dq, d_dbi}), 32'({16'h0F0F, 2'b00}));
            @(posedge clk);
            #1;
        end
        dif.s_valid = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/phy_burst_tx.md
Name: phy_burst_tx

Overview:
Parametrised source-synchronous burst transmitter for the PHY interface. It succeeds the single-byte start/data PHY front end. Write data arrives on a valid/ready stream into an internal FIFO. Fixed-length bursts are emitted on a DQ_W-wide dq bus with a differential dqs strobe, including preamble, postamble, output-enable control and seamless back-to-back bursts.

Parameters:
DQ_W, 8, dq bus width in bits (multiple of 8, ≥8)
BURST_LEN, 8, beats per burst (even, ≥2)
FIFO_DEPTH, 16, input FIFO entries (power of two, ≥BURST_LEN)
PRE_CYC, 1, preamble cycles (≥1)
POST_CYC, 1, postamble cycles (≥1)

Ports:
clk  in  1  sole clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
s_valid  in  1  input beat valid
s_ready  out  1  FIFO can accept a beat (= !full)
s_data  in  DQ_W  input beat
dq  out  DQ_W  registered data beat
dq_oe  out  1  dq output enable
dqs_p  out  1  strobe, true
dqs_n  out  1  strobe, complement
dqs_oe  out  1  strobe output enable
busy  out  1  state != IDLE
burst_done  out  1  one-cycle pulse on last data beat of each burst

Behaviour:
- Reset values: dq=0, dq_oe=0, dqs_p=0, dqs_n=1, dqs_oe=0, busy=0, burst_done=0, FIFO empty, state IDLE. s_ready=1 from the first cycle after rst deasserts.
- FIFO push when s_valid&&s_ready. Pop happens once per DATA cycle. Push and pop in the same cycle leave the count unchanged. The count is width $clog2(FIFO_DEPTH)+1. Pointers wrap at FIFO_DEPTH. No push is possible when full, because s_ready is low.
- All outputs are registered. dqs_n = ~dqs_p at all times.
- FSM states: IDLE, PRE, DATA, POST.
- IDLE:
  - Outputs are at their reset values.
  - If count ≥ BURST_LEN, the next cycle enters PRE.
  - A burst never starts with fewer than BURST_LEN entries, so underrun mid-burst is impossible.
- PRE:
  - PRE_CYC cycles with dqs_oe=1, dqs_p=0, dq_oe=0, dq=0.
  - Then enter DATA.
- DATA:
  - BURST_LEN cycles, beat index b=0..BURST_LEN-1.
  - Each cycle: dq = popped FIFO word, dq_oe=1, dqs_oe=1, dqs_p = ~b[0]. This gives dqs_p=1 on beat 0, so every strobe edge marks one beat.
  - burst_done=1 on beat BURST_LEN-1.
  - On the last beat, if count (after that beat's pop, including any same-cycle push) ≥ BURST_LEN, stay in DATA with b restarting at 0. This is seamless: no PRE/POST, and the strobe keeps toggling without a gap.
  - Otherwise enter POST.
- POST:
  - POST_CYC cycles with dqs_oe=1, dqs_p=0, dq_oe=0, dq=0.
  - Then enter IDLE, even if the FIFO has refilled; the next burst requires a fresh PRE.
- Latency: if the BURST_LEN-th entry is pushed at cycle N, PRE outputs appear at N+2 and the first data beat at N+2+PRE_CYC.
- Input order is preserved exactly across bursts.
- rst asserted in any state (including mid-DATA) aborts the burst, flushes the FIFO, and returns all outputs to reset values on the next edge. No postamble is emitted.

Optional Feature:
PHY_TX_DBI_EN
- Defined:
  - Adds output port dbi (width DQ_W/8), one bit per byte lane, reset value 0.
  - In DATA, a lane whose popped byte has more than 4 zero bits is driven inverted on dq, with its dbi bit set to 1. Otherwise the byte is driven unchanged with dbi=0.
  - dbi=0 outside DATA.
- Undefined: no dbi port; dq always carries raw data.

Test Plan:
- Single burst, defaults: push 0x01..0x08 back-to-back from cycle 0 → PRE at cycle 9 (dqs_oe=1, dqs_p=0). dq=0x01..0x08 on cycles 10..17 with dqs_p=1,0,1,0,1,0,1,0. burst_done on cycle 17. POST on cycle 18. busy=0 and dqs_oe=0 on cycle 19.
- Seamless: push 16 beats 0x10..0x1F continuously → 16 contiguous DATA beats, exactly one PRE and one POST, two burst_done pulses 8 cycles apart, dqs toggles every cycle through the burst boundary.
- Underfill: push 7 beats → busy stays 0 indefinitely. Push an 8th beat → burst starts 2 cycles later.
- Backpressure: hold s_valid=1 for 20 cycles with no burst possible before fill (PRE_CYC set large) → s_ready=0 once count=16, excess beats not accepted, no data lost or duplicated in the output sequence.
- Reset mid-burst: assert rst on data beat 3 → next cycle dq_oe=dqs_oe=0, dqs_p=0, dqs_n=1. After release, 8 new beats produce a clean burst containing only the new data.
- PHY_TX_DBI_EN, DQ_W=16: beat 0x00FF → dq=0xFFFF with dbi=2'b10. Beat 0x0F0F → dq=0x0F0F with dbi=2'b00.
